// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder controller: one full-adder cell plus a carry flip-flop
//   adds two WIDTH-bit operands LSB first, one bit per clock, sequenced by a
//   START/BUSY/DONE handshake. {COUT,S} = A + B + CIN (unsigned, mod 2^WIDTH).
//
//   Optional feature: define SERIAL_ADDER_OVF_EN to add the OVF port, which
//   reports signed overflow (carry-into-MSB XOR carry-out) with each result.
//
// Ports
//   CLK    in   rising-edge clock
//   RST    in   asynchronous active-high reset
//   START  in   begin an addition (accepted in IDLE or DONE)
//   A, B   in   WIDTH-bit operands, captured when START is accepted
//   CIN    in   carry-in, captured when START is accepted
//   BUSY   out  high while an addition is in progress
//   DONE   out  one-cycle pulse when S/COUT (and OVF) are updated
//   S      out  registered sum, held between completions
//   COUT   out  registered carry-out of bit WIDTH-1
//   OVF    out  signed overflow (SERIAL_ADDER_OVF_EN only)

module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             cf;
    logic [CNT_W-1:0] cnt;

    // The single shared full-adder cell.
    logic             sum_bit;
    logic             carry_bit;
    logic [WIDTH-1:0] sr_next;

    always_comb begin
        sum_bit   = sa[0] ^ sb[0] ^ cf;
        carry_bit = (sa[0] & sb[0]) | (sa[0] & cf) | (sb[0] & cf);
        sr_next   = {sum_bit, sr[WIDTH-1:1]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            cf    <= 1'b0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            S     <= '0;
            COUT  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            OVF   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        sa    <= A;
                        sb    <= B;
                        cf    <= CIN;
                        sr    <= '0;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    sr  <= sr_next;
                    cf  <= carry_bit;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        // On the MSB step cf still holds the carry into bit
                        // WIDTH-1, so overflow falls out without another flop.
                        S     <= sr_next;
                        COUT  <= carry_bit;
`ifdef SERIAL_ADDER_OVF_EN
                        OVF   <= cf ^ carry_bit;
`endif
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= ST_DONE;
                    end
                end

                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=4.
module tb_serial_adder_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] A;
    logic [3:0] B;
    logic       CIN;
    logic       BUSY;
    logic       DONE;
    logic [3:0] S;
    logic       COUT;
`ifdef SERIAL_ADDER_OVF_EN
    logic       OVF;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_adder_ctrl #(.WIDTH(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .A    (A),
        .B    (B),
        .CIN  (CIN),
        .BUSY (BUSY),
        .DONE (DONE),
        .S    (S),
        .COUT (COUT)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF  (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present operands with START for one edge, then scramble the operands.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic cin);
        A = a; B = b; CIN = cin; START = 1'b1;
        tick();
        START = 1'b0; A = ~a; B = ~b; CIN = ~cin;
    endtask

    // Advance until DONE (bounded); note whether S/COUT stayed at the hold values.
    task automatic wait_done(input logic [3:0] hold_s, input logic hold_c,
                             output int cycles, output bit held);
        cycles = 0;
        held   = 1'b1;
        do begin
            tick();
            cycles++;
            if (DONE !== 1'b1 && (S !== hold_s || COUT !== hold_c)) held = 1'b0;
        end while (DONE !== 1'b1 && cycles < 20);
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
        repeat (3) tick();
        n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        n_checks++; if (DONE !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", DONE); end
        n_checks++; if (S !== 4'd0) begin n_errors++; $display("FAIL reset_s got %0d want 0", S); end
        n_checks++; if (COUT !== 1'b0) begin n_errors++; $display("FAIL reset_cout got %b want 0", COUT); end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++; if (OVF !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b want 0", OVF); end
`endif
        RST = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        int cyc; bit held;
        start_op(4'd0, 4'd0, 1'b0);
        n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL zero_busy_rise got %b want 1", BUSY); end
        wait_done(4'd0, 1'b0, cyc, held);
        n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL zero_latency got %0d want 4", cyc); end
        n_checks++; if (S !== 4'd0 || COUT !== 1'b0) begin n_errors++; $display("FAIL zero_result got s=%0d c=%b want s=0 c=0", S, COUT); end
        n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL zero_busy_fall got %b want 0", BUSY); end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++; if (OVF !== 1'b0) begin n_errors++; $display("FAIL zero_ovf got %b want 0", OVF); end
`endif
        tick();
        n_checks++; if (DONE !== 1'b0) begin n_errors++; $display("FAIL zero_done_pulse got %b want 0", DONE); end
    endtask

    task automatic test_arith();
        logic [3:0] va[2] = '{4'd6, 4'd5};
        logic [3:0] vb[2] = '{4'd10, 4'd2};
        logic       vc[2] = '{1'b0, 1'b1};
        logic [3:0] es[2] = '{4'd0, 4'd8};
        logic       ec[2] = '{1'b1, 1'b0};
        logic       eo[2] = '{1'b0, 1'b1};
        logic [3:0] hs = 4'd0;
        logic       hc = 1'b0;
        int cyc; bit held;
        for (int unsigned i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], vc[i]);
            wait_done(hs, hc, cyc, held);
            n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL arith%0d_latency got %0d want 4", i, cyc); end
            n_checks++; if (!held) begin n_errors++; $display("FAIL arith%0d_hold got changed want s=%0d c=%b", i, hs, hc); end
            n_checks++; if (S !== es[i] || COUT !== ec[i]) begin n_errors++; $display("FAIL arith%0d_result got s=%0d c=%b want s=%0d c=%b", i, S, COUT, es[i], ec[i]); end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++; if (OVF !== eo[i]) begin n_errors++; $display("FAIL arith%0d_ovf got %b want %b", i, OVF, eo[i]); end
`endif
            hs = es[i]; hc = ec[i];
            tick();
        end
    endtask

    task automatic test_all_ones();
        int cyc; bit held;
        start_op(4'd15, 4'd15, 1'b1);
        wait_done(4'd8, 1'b0, cyc, held);
        n_checks++; if (!held) begin n_errors++; $display("FAIL ones_hold got changed want s=8 c=0"); end
        n_checks++; if (S !== 4'd15 || COUT !== 1'b1) begin n_errors++; $display("FAIL ones_result got s=%0d c=%b want s=15 c=1", S, COUT); end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++; if (OVF !== 1'b0) begin n_errors++; $display("FAIL ones_ovf got %b want 0", OVF); end
`endif
        tick();
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        logic [3:0] s_at_done = 4'd0;
        logic       c_at_done = 1'b0;
        start_op(4'd5, 4'd2, 1'b1);
        tick();
        A = 4'd1; B = 4'd1; CIN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (DONE === 1'b1) begin dones++; s_at_done = S; c_at_done = COUT; end
            tick();
        end
        n_checks++; if (dones !== 1) begin n_errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        n_checks++; if (s_at_done !== 4'd8 || c_at_done !== 1'b0) begin n_errors++; $display("FAIL ignore_result got s=%0d c=%b want s=8 c=0", s_at_done, c_at_done); end
        n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL ignore_idle got busy=%b want 0", BUSY); end
    endtask

    task automatic test_reset_abort();
        int cyc; bit held;
        start_op(4'd7, 4'd7, 1'b0);
        tick();
        tick();
        RST = 1'b1;
        #1;
        n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", BUSY); end
        n_checks++; if (S !== 4'd0 || COUT !== 1'b0) begin n_errors++; $display("FAIL abort_result got s=%0d c=%b want s=0 c=0", S, COUT); end
        #2;
        RST = 1'b0;
        tick();
        start_op(4'd3, 4'd4, 1'b0);
        wait_done(4'd0, 1'b0, cyc, held);
        n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL after_abort_latency got %0d want 4", cyc); end
        n_checks++; if (S !== 4'd7 || COUT !== 1'b0) begin n_errors++; $display("FAIL after_abort_result got s=%0d c=%b want s=7 c=0", S, COUT); end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++; if (OVF !== 1'b0) begin n_errors++; $display("FAIL after_abort_ovf got %b want 0", OVF); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc; bit held;
        logic [3:0] hs = 4'd7;
        logic       hc = 1'b0;
        A = 4'd9; B = 4'd9; CIN = 1'b0; START = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_done(hs, hc, cyc, held);
            n_checks++; if (cyc !== ((k == 0) ? 4 : 5)) begin n_errors++; $display("FAIL b2b%0d_interval got %0d want %0d", k, cyc, (k == 0) ? 4 : 5); end
            n_checks++; if (S !== 4'd2 || COUT !== 1'b1) begin n_errors++; $display("FAIL b2b%0d_result got s=%0d c=%b want s=2 c=1", k, S, COUT); end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++; if (OVF !== 1'b1) begin n_errors++; $display("FAIL b2b%0d_ovf got %b want 1", k, OVF); end
`endif
            hs = 4'd2; hc = 1'b1;
        end
        START = 1'b0;
        tick();
        tick();
        n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_errors++; $display("FAIL b2b_stop got busy=%b done=%b want 0 0", BUSY, DONE); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_arith();
        test_all_ones();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that time-shares a single one-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It sits between an operand source and the arithmetic datapath. It replaces a WIDTH-cell ripple chain with one cell plus a carry flip-flop, trading latency for area. A START/BUSY/DONE handshake sequences each operation.

## Interface
- WIDTH, 4: operand and sum width in bits; legal range 2..32.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request to begin an addition; sampled on rising CLK.
- A  in  WIDTH  operand A; captured when START is accepted.
- B  in  WIDTH  operand B; captured when START is accepted.
- CIN  in  1  carry-in; captured when START is accepted.
- BUSY  out  1  high while an addition is in progress.
- DONE  out  1  one-cycle pulse: S, COUT (and OVF) valid.
- S  out  WIDTH  registered sum.
- COUT  out  1  registered carry-out of bit WIDTH-1.
- OVF  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- Internals: one full-adder cell (A, B, CIN -> S, COUT), operand shift registers SA/SB, carry flip-flop CF, sum shift register SR, bit counter CNT of width clog2(WIDTH).
- State IDLE: BUSY=0. If START=1, load SA=A, SB=B, CF=CIN, CNT=0, and go to RUN.
- State RUN: BUSY=1. Each cycle, the cell adds SA[0], SB[0] and CF.
  - The sum bit shifts into SR at the MSB end; SR shifts right.
  - The cell carry-out loads CF; SA and SB shift right; CNT increments.
  - When CNT=WIDTH-1, copy the final SR to S and the final carry to COUT, then go to DONE.
- State DONE: DONE=1 for exactly one cycle. If START=1, reload as in IDLE and go to RUN; otherwise go to IDLE.
- START during RUN is ignored. No queuing; the operands already in flight are unaffected.
- A, B and CIN are don't-care except in the cycle START is accepted.
- S and COUT hold their last result until the next completion; they do not change during RUN.
- Arithmetic is unsigned modulo 2^WIDTH, with carry exported on COUT. {COUT,S} = A + B + CIN.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, S=0, COUT=0, OVF=0; SA, SB, SR, CF and CNT are cleared.
- RST asserted mid-RUN aborts immediately and asynchronously. Outputs go to reset values; the partial result is discarded.
- START is sampled high at edge t0:
  - BUSY rises after t0.
  - Bits are processed on edges t0+1 through t0+WIDTH.
  - S, COUT and DONE update after edge t0+WIDTH; DONE is high for one cycle.
  - BUSY falls after t0+WIDTH.
- Latency is WIDTH cycles from START acceptance to DONE.
- Back-to-back throughput: START held high gives one result every WIDTH+1 cycles. The restart from DONE costs no idle cycle beyond the DONE cycle itself.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - OVF port exists. A flip-flop records the carry into bit WIDTH-1.
  - At completion, OVF = carry-into-MSB XOR COUT. It is updated with S and held until the next completion.
- SERIAL_ADDER_OVF_EN undefined: no OVF port and no extra flip-flop; behaviour is otherwise identical.

## Test plan
- WIDTH=4, A=0, B=0, CIN=0, START for 1 cycle -> DONE 4 cycles later, S=0, COUT=0, OVF=0.
- A=6, B=10, CIN=0 -> S=0, COUT=1, OVF=0. Then A=5, B=2, CIN=1 -> S=8, COUT=0, OVF=1.
- A=15, B=15, CIN=1 -> S=15, COUT=1, OVF=0. S must hold its previous value on every cycle BUSY=1.
- START pulsed again 2 cycles into RUN with A=1, B=1 -> ignored; the original result is returned and exactly one DONE pulse occurs.
- RST asserted 2 cycles into RUN -> BUSY=0, S=0, COUT=0 immediately. After release, a new START with A=3, B=4, CIN=0 gives S=7.
- START held high continuously with fixed A=9, B=9, CIN=0 -> DONE every 5 cycles, S=2, COUT=1 each time.
